// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the 8:1 mux scan sequencer.
package mux_scan_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/next_en_ch.sv
// Enabled-channel lookup: first enabled channel, or next enabled channel above cur.
module next_en_ch
  import mux_scan_pkg::*;
(
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             first,
  output logic [SEL_W-1:0] nxt,
  output logic             has_nxt
);

  logic [SEL_W-1:0] low_idx;
  logic [SEL_W-1:0] up_idx;
  logic             any_set;
  logic             up_set;

  // Descending walk: the last hit written is the lowest qualifying index.
  always_comb begin
    low_idx = '0;
    up_idx  = '0;
    any_set = 1'b0;
    up_set  = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_idx = SEL_W'(i);
        any_set = 1'b1;
      end
      if (mask[i] && (i > int'(cur))) begin
        up_idx = SEL_W'(i);
        up_set = 1'b1;
      end
    end
  end

  always_comb begin
    nxt     = low_idx;
    has_nxt = any_set;
    if (!first) begin
      has_nxt = up_set;
      if (up_set) begin
        nxt = up_idx;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans enabled channels of an 8:1 bit mux, dwelling DWELL clocks on each,
// and publishes one captured byte per scan with a one-cycle strobe.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       cont,
  input  logic [7:0] ch_en,
  input  logic       mux_o,
  output logic [2:0] sel,
  output logic       busy,
  output logic       frame_valid,
  output logic [7:0] frame_data
);

  localparam int CNT_W = $clog2(DWELL + 1);

  state_t state_q;
  state_t state_d;

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [N_CH-1:0]  mask_q;
  logic [N_CH-1:0]  mask_d;
  logic [N_CH-1:0]  acc_q;
  logic [N_CH-1:0]  acc_d;
  logic [N_CH-1:0]  frame_q;
  logic [N_CH-1:0]  frame_d;

  logic [SEL_W-1:0] first_ch;
  logic [SEL_W-1:0] next_ch;
  logic             first_ok;
  logic             next_ok;
  logic             dwell_end;
  logic             go;
  logic             restart;
  logic             load;
  logic             in_scan;
  logic             scan_kill;
  logic             publish;

  next_en_ch u_first (
    .mask    (ch_en),
    .cur     ('0),
    .first   (1'b1),
    .nxt     (first_ch),
    .has_nxt (first_ok)
  );

  next_en_ch u_next (
    .mask    (mask_q),
    .cur     (sel_q),
    .first   (1'b0),
    .nxt     (next_ch),
    .has_nxt (next_ok)
  );

  assign dwell_end = (cnt_q == CNT_W'(DWELL - 1));
  assign go        = start && !abort && first_ok;
  assign restart   = (state_q == DONE) && !abort && cont && first_ok;
  assign load      = ((state_q == IDLE) && go) || restart;
  assign in_scan   = (state_q == SCAN) && !abort;
  assign scan_kill = (state_q == SCAN) && abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (go) state_d = SCAN;
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dwell_end && !next_ok) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (restart) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Abort in DONE suppresses the strobe in the same cycle.
  always_comb begin
    publish     = (state_q == DONE) && !abort;
    busy        = (state_q != IDLE);
    frame_valid = publish;
    frame_data  = publish ? acc_q : frame_q;
    sel         = sel_q;
  end

  always_comb begin
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    frame_d = frame_q;
    if (publish) begin
      frame_d = acc_q;
    end
    unique case (1'b1)
      load: begin
        mask_d = ch_en;
        acc_d  = '0;
        sel_d  = first_ch;
        cnt_d  = '0;
      end
      scan_kill: begin
        acc_d = '0;
        cnt_d = '0;
      end
      in_scan: begin
        if (dwell_end) begin
          acc_d[sel_q] = mux_o;
          cnt_d        = '0;
          if (next_ok) begin
            sel_d = next_ch;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      frame_q <= '0;
    end else begin
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed + randomized checks of the scan sequencer at DWELL=4 and DWELL=1
// against a channel-list model of the scan.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic       abort = 1'b0;
  logic       cont = 1'b0;
  logic [7:0] ch_en = 8'h00;
  logic [7:0] pat = 8'h00;

  logic       mux_o, mux_o1;
  logic [2:0] sel, sel1;
  logic       busy, busy1;
  logic       fv, fv1;
  logic [7:0] fd, fd1;

  int n_pass = 0;
  int n_chk = 0;
  logic [7:0] last0 = 8'h00;
  logic [7:0] last1 = 8'h00;

  always #5 clk = ~clk;

  assign mux_o  = pat[sel];
  assign mux_o1 = pat[sel1];

  mux_scan_sequencer #(.DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cont(cont), .ch_en(ch_en), .mux_o(mux_o), .sel(sel),
    .busy(busy), .frame_valid(fv), .frame_data(fd)
  );

  mux_scan_sequencer #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .cont(cont), .ch_en(ch_en), .mux_o(mux_o1), .sel(sel1),
    .busy(busy1), .frame_valid(fv1), .frame_data(fd1)
  );

  function automatic logic [31:0] o_sel(input bit u1);
    return u1 ? 32'(sel1) : 32'(sel);
  endfunction
  function automatic logic [31:0] o_fv(input bit u1);
    return u1 ? 32'(fv1) : 32'(fv);
  endfunction
  function automatic logic [31:0] o_busy(input bit u1);
    return u1 ? 32'(busy1) : 32'(busy);
  endfunction
  function automatic logic [31:0] o_fd(input bit u1);
    return u1 ? 32'(fd1) : 32'(fd);
  endfunction
  function automatic logic [31:0] top_ch(input logic [7:0] m);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 8; i++) if (m[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [7:0] m, input bit u1);
    ch_en = m;
    if (u1) start1 = 1'b1;
    else start = 1'b1;
    step();
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  // Expected scan: enabled channels ascending, each held dw cycles, then one
  // strobe cycle carrying pattern & mask. Mask wobble mid-frame is ignored.
  task automatic body(input logic [7:0] m, input logic [7:0] p,
                      input int dw, input bit u1);
    int n;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        for (int d = 0; d < dw; d++) begin
          chk("sel", o_sel(u1), c);
          chk("fv_early", o_fv(u1), 0);
          chk("busy_scan", o_busy(u1), 1);
          if (n == 0) ch_en = 8'($urandom);
          n++;
          step();
        end
      end
    end
    ch_en = m;
    chk("fv_done", o_fv(u1), 1);
    chk("busy_done", o_busy(u1), 1);
    chk("frame", o_fd(u1), 32'(p & m));
  endtask

  task automatic frame(input logic [7:0] m, input logic [7:0] p,
                       input bit u1);
    pat = p;
    kick(m, u1);
    body(m, p, u1 ? 1 : 4, u1);
    step();
    chk("fv_after", o_fv(u1), 0);
    chk("busy_after", o_busy(u1), 0);
    chk("frame_hold", o_fd(u1), 32'(p & m));
    chk("sel_hold", o_sel(u1), top_ch(m));
    if (u1) last1 = p & m;
    else last0 = p & m;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic seen;
    logic [7:0] rm, rp;
    bit ru;

    #12;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fv", 32'(fv), 0);
    chk("rst_fd", 32'(fd), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // T1, T2
    frame(8'hFF, 8'hA5, 1'b0);
    frame(8'b1000_0101, 8'hFF, 1'b0);

    // T3 continuous
    cont = 1'b1;
    pat  = 8'h03;
    kick(8'h0F, 1'b0);
    body(8'h0F, 8'h03, 4, 1'b0);
    pat = 8'h0C;
    step();
    cont = 1'b0;
    body(8'h0F, 8'h0C, 4, 1'b0);
    step();
    chk("cont_idle", 32'(busy), 0);
    last0 = 8'h0C;

    // T4 abort mid-frame on channel 3
    pat = 8'($urandom);
    kick(8'hFF, 1'b0);
    repeat (13) step();
    chk("ab_sel3", 32'(sel), 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_sel", 32'(sel), 3);
    chk("ab_fd", 32'(fd), 32'(last0));
    seen = 1'b0;
    repeat (40) begin
      step();
      seen |= fv;
    end
    chk("ab_nofv", 32'(seen), 0);

    // T4 abort in DONE
    pat = 8'($urandom);
    kick(8'h0F, 1'b0);
    repeat (16) step();
    chk("abd_busy", 32'(busy), 1);
    abort = 1'b1;
    #1;
    chk("abd_fv", 32'(fv), 0);
    chk("abd_fd", 32'(fd), 32'(last0));
    step();
    abort = 1'b0;
    chk("abd_idle", 32'(busy), 0);
    chk("abd_fd2", 32'(fd), 32'(last0));

    // T5 reset mid-scan
    pat = 8'hFF;
    kick(8'hFF, 1'b0);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("ar_sel", 32'(sel), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_fv", 32'(fv), 0);
    chk("ar_fd", 32'(fd), 0);
    last0 = 8'h00;
    last1 = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    kick(8'h00, 1'b0);
    chk("zero_mask", 32'(busy), 0);
    seen = 1'b0;
    repeat (5) begin
      step();
      seen |= fv;
    end
    chk("zero_nofv", 32'(seen), 0);

    abort = 1'b1;
    kick(8'hFF, 1'b0);
    abort = 1'b0;
    chk("st_ab_busy", 32'(busy), 0);
    chk("st_ab_sel", 32'(sel), 0);

    // T6 DWELL=1
    frame(8'hFF, 8'h5A, 1'b1);

    // randomized frames on both builds
    for (int k = 0; k < 10; k++) begin
      rm = 8'($urandom_range(1, 255));
      rp = 8'($urandom);
      ru = bit'($urandom_range(0, 1));
      frame(rm, rp, ru);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
